// File: rtl/serial_subtractor_pkg.sv
// ============================================================================
// Module      : serial_subtractor_pkg
// Description : Shared state encoding and default width for the serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_e;

  localparam int SUB_W_DEFAULT = 8;

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_if.sv
// ============================================================================
// Module      : serial_subtractor_if
// Description : Start/done operand and result bundle for the serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int W = SUB_W_DEFAULT
);

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );

endinterface

`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
// ============================================================================
// Module      : full_subtractor
// Description : One-bit combinational subtract cell: d = a - b - bi, borrow bo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor (
  input  wire logic a,
  input  wire logic b,
  input  wire logic bi,
  output logic      d,
  output logic      bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial W-bit subtractor, LSB first, registered borrow chain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int W = SUB_W_DEFAULT
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  serial_subtractor_if.slave sub
);

  localparam int             CW      = $clog2(W + 1);
  localparam logic [1:0]     c_idle  = IDLE;
  localparam logic [1:0]     c_shift = SHIFT;
  localparam logic [1:0]     c_done  = DONE;
  localparam logic [CW-1:0]  c_last  = CW'(W - 1);

  logic [1:0]    r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_res;
  logic          r_br;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic [W-1:0]  r_diff;
  logic          r_bout;

  logic          w_d;
  logic          w_bo;
  logic [W-1:0]  w_res_next;

  full_subtractor u_fs (
    .a  (r_a[0]),
    .b  (r_b[0]),
    .bi (r_br),
    .d  (w_d),
    .bo (w_bo)
  );

  // New bit enters at the MSB so the register is LSB-aligned after W shifts.
  generate
    if (W == 1) begin : g_res_w1
      assign w_res_next = w_d;
    end else begin : g_res_wn
      assign w_res_next = {w_d, r_res[W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_idle, c_done: begin
          if (sub.start) begin
            r_a     <= sub.a;
            r_b     <= sub.b;
            r_br    <= sub.bin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= c_shift;
          end else begin
            r_state <= c_idle;
          end
        end
        c_shift: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_bo;
          r_res <= w_res_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == c_last) begin
            r_diff  <= w_res_next;
            r_bout  <= w_bo;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= c_done;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= c_idle;
        end
      endcase
    end
  end

  assign sub.busy = r_busy;
  assign sub.done = r_done;
  assign sub.diff = r_diff;
  assign sub.bout = r_bout;

endmodule

`default_nettype wire
